alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the single-cycle MIPS datapath.
- First operand comes from register-file port A; second operand is register B or the extended immediate, selected upstream.
- Produces the result, a zero flag for branch decisions, a signed-overflow flag and a sticky overflow status bit.
- Datapath is combinational by default; the clock drives only the sticky status and the optional output register.

Parameters:
- WIDTH, 32, operand/result width in bits; all behaviour below is stated for 32.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alu_in1  input  WIDTH  operand A (register port A)
- alu_in2  input  WIDTH  operand B (register B or immediate)
- alu_op  input  3  operation select
- alu_out  output  WIDTH  result
- alu_zout  output  1  1 when alu_out == 0
- alu_ovf  output  1  signed overflow of ADD/SUB; 0 for every other op
- ovf_sticky  output  1  latched overflow status

Behaviour:
- Op encoding (alu_op):
  - 000 AND: A & B
  - 001 OR: A | B
  - 010 ADD: A + B, modulo 2^32
  - 011 XOR: A ^ B
  - 100 NOR: ~(A | B)
  - 101 SLTU: {31'b0, A < B unsigned}
  - 110 SUB: A - B, modulo 2^32
  - 111 SLT: {31'b0, A < B signed}
- SLT uses the true signed comparison (sign of the difference XOR overflow), not the raw difference sign. Example: A=0x80000000, B=1 -> 1.
- Overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - Overflow never raises an exception and never changes alu_out (wrapped result is output).
- alu_zout = (alu_out == 0) for all ops, including SLT/SLTU results.
- Default build: alu_out, alu_zout, alu_ovf are purely combinational, zero cycles latency, and valid in the same cycle inputs change. No X propagation for defined inputs.
- ovf_sticky:
  - Set on each rising clk edge where alu_ovf == 1.
  - Holds until rst.
  - rst (async) forces it to 0 immediately.
  - If rst is asserted while alu_ovf == 1, it stays 0 for as long as rst is high.
- Reset does not affect the combinational outputs.
- Undefined ops: none; all 8 codes are defined.

Optional Feature:
- Macro ALU_OUT_REG_EN.
- Defined:
  - alu_out, alu_zout, alu_ovf are registered on rising clk, giving 1-cycle latency.
  - rst asynchronously clears alu_out=0, alu_ovf=0, alu_zout=1 (consistent with the zero result).
  - ovf_sticky samples the registered alu_ovf.
- Undefined: combinational outputs as above.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum with the eight codes above.
  - Constant ALU_W = 32.
- One sub-module, alu_addsub: a shared adder/subtractor producing sum, carry-out and signed overflow. It serves ADD, SUB, SLT and SLTU (SLTU = borrow from A - B). The top level holds the logic ops, the result mux, the zero detect and the sticky register.

Test Plan:
- ADD: A=0x00000005, B=0x00000003, op=010 -> out=0x00000008, zout=0, ovf=0.
- SUB equal operands: A=B=0x12345678, op=110 -> out=0, zout=1, ovf=0 (branch-equal case).
- ADD signed overflow: A=0x7FFFFFFF, B=1, op=010 -> out=0x80000000, ovf=1. Next clk edge -> ovf_sticky=1; remains 1 after op changes; async rst pulse -> ovf_sticky=0 without waiting for a clk edge.
- SLT vs SLTU: A=0xFFFFFFFF, B=1. SLT (111) -> out=1, zout=0. SLTU (101) -> out=0, zout=1. A=0x80000000, B=0x7FFFFFFF, SLT -> out=1.
- Logic ops: A=0xF0F0F0F0, B=0x0FF00FF0.
  - AND -> 0x00F000F0
  - OR -> 0xFFF0FFF0
  - XOR -> 0xFF00FF00
  - NOR -> 0x000F000F
- ALU_OUT_REG_EN build: apply ADD 2+2 -> out stays at the previous value until the next rising edge, then 4. rst mid-operation -> out=0, zout=1 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the single-cycle MIPS ALU.
//   ALU_W    : default operand/result width
//   alu_op_e : 3-bit operation select encoding
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_XOR  = 3'b011,
        OP_NOR  = 3'b100,
        OP_SLTU = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor for ADD, SUB, SLT and SLTU.
// Ports:
//   a_i    : operand A
//   b_i    : operand B
//   sub_i  : 1 = A - B (two's complement), 0 = A + B
//   sum_o  : wrapped sum/difference
//   cout_o : carry out; for subtraction, ~cout_o is the unsigned borrow
//   ovf_o  : signed overflow of the add/subtract
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff  = sub_i ? ~b_i : b_i;
        full   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
        sum_o  = full[WIDTH-1:0];
        cout_o = full[WIDTH];
        // Same sign on the effective adder inputs but a different result
        // sign covers both the ADD and SUB overflow rules.
        ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU for the single-cycle MIPS datapath.
// Ports:
//   clk        : clock (rising edge), drives sticky status / optional output regs
//   rst        : asynchronous active-high reset
//   alu_in1    : operand A (register port A)
//   alu_in2    : operand B (register B or extended immediate)
//   alu_op     : operation select (see alu_pkg::alu_op_e)
//   alu_out    : result
//   alu_zout   : 1 when alu_out == 0
//   alu_ovf    : signed overflow of ADD/SUB, 0 for all other ops
//   ovf_sticky : latched overflow status, cleared only by rst
// Build option:
//   ALU_OUT_REG_EN : register alu_out/alu_zout/alu_ovf (1-cycle latency);
//                    rst clears them to out=0, zout=1, ovf=0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zout,
    output logic             alu_ovf,
    output logic             ovf_sticky
);

    alu_op_e          op;
    logic             use_sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             as_ovf;
    logic [WIDTH-1:0] res_d;
    logic             zout_d;
    logic             ovf_d;
    logic             sticky_q;

    assign op      = alu_op_e'(alu_op);
    assign use_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a_i   (alu_in1),
        .b_i   (alu_in2),
        .sub_i (use_sub),
        .sum_o (sum),
        .cout_o(cout),
        .ovf_o (as_ovf)
    );

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (op)
            OP_AND:  res_d = alu_in1 & alu_in2;
            OP_OR:   res_d = alu_in1 | alu_in2;
            OP_ADD: begin
                res_d = sum;
                ovf_d = as_ovf;
            end
            OP_XOR:  res_d = alu_in1 ^ alu_in2;
            OP_NOR:  res_d = ~(alu_in1 | alu_in2);
            // Borrow out of A - B is the inverted carry.
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, ~cout};
            OP_SUB: begin
                res_d = sum;
                ovf_d = as_ovf;
            end
            // True signed less-than: difference sign corrected by overflow.
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ as_ovf};
            default: res_d = '0;
        endcase
        zout_d = (res_d == '0);
    end

`ifdef ALU_OUT_REG_EN
    logic [WIDTH-1:0] out_q;
    logic             zout_q;
    logic             ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            zout_q <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= res_d;
            zout_q <= zout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign alu_out  = out_q;
    assign alu_zout = zout_q;
    assign alu_ovf  = ovf_q;
`else
    assign alu_out  = res_d;
    assign alu_zout = zout_d;
    assign alu_ovf  = ovf_d;
`endif

    // Sticky sees the visible flag, so it tracks the registered flag when
    // the output register is built in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (alu_ovf) begin
            sticky_q <= 1'b1;
        end
    end

    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zout;
    logic        alu_ovf;
    logic        ovf_sticky;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_zout  (alu_zout),
        .alu_ovf   (alu_ovf),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation and wait until its result is visible.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
`ifdef ALU_OUT_REG_EN
        @(negedge clk);
        alu_in1 = a;
        alu_in2 = b;
        alu_op  = op;
        @(posedge clk);
        #1;
`else
        alu_in1 = a;
        alu_in2 = b;
        alu_op  = op;
        #1;
`endif
    endtask

    // Vector check of out/zout/ovf against hand-computed values.
    task automatic test_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [31:0] eo, input logic ez,
                            input logic ev);
        apply(a, b, op);
        checks++;
        if (alu_out !== eo) begin
            failures++;
            $display("FAIL %s out: got %h expected %h", name, alu_out, eo);
        end
        checks++;
        if (alu_zout !== ez) begin
            failures++;
            $display("FAIL %s zout: got %b expected %b", name, alu_zout, ez);
        end
        checks++;
        if (alu_ovf !== ev) begin
            failures++;
            $display("FAIL %s ovf: got %b expected %b", name, alu_ovf, ev);
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        alu_in1 = '0;
        alu_in2 = '0;
        alu_op  = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL reset sticky: got %b expected 0", ovf_sticky);
        end
`ifdef ALU_OUT_REG_EN
        checks++;
        if (alu_out !== 32'h0 || alu_zout !== 1'b1 || alu_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset regs: got out=%h z=%b v=%b expected 0/1/0",
                     alu_out, alu_zout, alu_ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith;
        test_vec("add_5_3",     32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0008, 1'b0, 1'b0);
        test_vec("sub_equal",   32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000, 1'b1, 1'b0);
        test_vec("add_wrap0",   32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000, 1'b1, 1'b0);
        test_vec("sub_ovf",     32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1);
        test_vec("sub_neg",     32'h0000_0003, 32'h0000_0005, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0);
    endtask

    task automatic test_compare;
        test_vec("slt_m1_1",    32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0);
        test_vec("sltu_m1_1",   32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 32'h0000_0000, 1'b1, 1'b0);
        test_vec("slt_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h0000_0001, 1'b0, 1'b0);
        test_vec("slt_min_1",   32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b0);
        test_vec("slt_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0000_0000, 1'b1, 1'b0);
        test_vec("sltu_1_m1",   32'h0000_0001, 32'hFFFF_FFFF, 3'b101, 32'h0000_0001, 1'b0, 1'b0);
        test_vec("sltu_eq",     32'h0000_0007, 32'h0000_0007, 3'b101, 32'h0000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_logic;
        test_vec("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0, 1'b0);
        test_vec("or",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0);
        test_vec("xor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'hFF00_FF00, 1'b0, 1'b0);
        test_vec("nor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b100, 32'h000F_000F, 1'b0, 1'b0);
        test_vec("nor_ones", 32'hFFFF_0000, 32'h0000_FFFF, 3'b100, 32'h0000_0000, 1'b1, 1'b0);
    endtask

    task automatic test_overflow_sticky;
        test_vec("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_set: got %b expected 1", ovf_sticky);
        end
        test_vec("and_after", 32'h0000_000F, 32'h0000_0003, 3'b000, 32'h0000_0003, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_hold: got %b expected 1", ovf_sticky);
        end
        // Async clear between edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_async_clr: got %b expected 0", ovf_sticky);
        end
        rst = 1'b0;
    endtask

    task automatic test_sticky_under_reset;
        @(negedge clk);
        alu_in1 = 32'h7FFF_FFFF;
        alu_in2 = 32'h0000_0001;
        alu_op  = 3'b010;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_in_rst: got %b expected 0", ovf_sticky);
        end
        @(negedge clk);
        alu_op = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_after_rst: got %b expected 0", ovf_sticky);
        end
    endtask

    task automatic test_back_to_back;
        // Consecutive ops with no gap; each must reflect only its own inputs.
        test_vec("b2b_add", 32'h0000_0002, 32'h0000_0002, 3'b010, 32'h0000_0004, 1'b0, 1'b0);
        test_vec("b2b_sub", 32'h0000_0004, 32'h0000_0004, 3'b110, 32'h0000_0000, 1'b1, 1'b0);
        test_vec("b2b_or",  32'h0000_0000, 32'h8000_0000, 3'b001, 32'h8000_0000, 1'b0, 1'b0);
`ifdef ALU_OUT_REG_EN
        // Output must hold the previous value until the next rising edge.
        @(negedge clk);
        alu_in1 = 32'h0000_0002;
        alu_in2 = 32'h0000_0002;
        alu_op  = 3'b010;
        #1;
        checks++;
        if (alu_out !== 32'h8000_0000) begin
            failures++;
            $display("FAIL reg_hold: got %h expected 80000000", alu_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (alu_out !== 32'h0000_0004) begin
            failures++;
            $display("FAIL reg_update: got %h expected 00000004", alu_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (alu_out !== 32'h0 || alu_zout !== 1'b1) begin
            failures++;
            $display("FAIL reg_async_rst: got out=%h z=%b expected 0/1", alu_out, alu_zout);
        end
        @(negedge clk);
        rst = 1'b0;
`else
        // Combinational path: result follows inputs without a clock edge.
        @(negedge clk);
        alu_in1 = 32'h0000_0002;
        alu_in2 = 32'h0000_0002;
        alu_op  = 3'b010;
        #1;
        checks++;
        if (alu_out !== 32'h0000_0004) begin
            failures++;
            $display("FAIL comb_now: got %h expected 00000004", alu_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (alu_out !== 32'h0000_0004 || alu_zout !== 1'b0) begin
            failures++;
            $display("FAIL comb_rst_indep: got out=%h z=%b expected 4/0", alu_out, alu_zout);
        end
        rst = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_logic();
        test_overflow_sticky();
        test_sticky_under_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
